// File: rtl/car_flow_generator.sv
// car_flow_generator: pseudo-random per-direction traffic source for a
// four-way signal controller. Arrivals come from one 16-bit LFSR per
// direction. Departures are gated by the green axis and bounded by a
// shadow queue, so every emitted count is physically consistent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no traffic, counts forced to 0, LFSRs hold
// S_RUN   | arrivals and gated departures, LFSRs advance
// S_DRAIN | arrivals stopped, departures continue until queues empty
module car_flow_generator #(
  parameter logic [15:0] SEED_W      = 16'hACE1,
  parameter logic [15:0] SEED_E      = 16'h1D2B,
  parameter logic [15:0] SEED_N      = 16'h7F03,
  parameter logic [15:0] SEED_S      = 16'h3C55,
  parameter int unsigned MAX_ARRIVE  = 3,
  parameter int unsigned DEPART_RATE = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic       ns_green,
  input  logic       ew_green,
  output logic [4:0] w_incomingCars,
  output logic [4:0] e_incomingCars,
  output logic [4:0] n_incomingCars,
  output logic [4:0] s_incomingCars,
  output logic [4:0] w_leavingCars,
  output logic [4:0] e_leavingCars,
  output logic [4:0] n_leavingCars,
  output logic [4:0] s_leavingCars,
  output logic [6:0] total_queued,
  output logic       busy,
  output logic       done,
  output logic       conflict
);

  localparam logic [2:0] LP_MAX = 3'(MAX_ARRIVE);
  localparam logic [4:0] LP_DEP = 5'(DEPART_RATE);
  localparam logic [4:0] LP_CAP = 5'd31;

  // Direction index: 0 = W, 1 = E (east/west axis), 2 = N, 3 = S (north/south axis)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_lfsr [4];
  logic [4:0]  r_q    [4];
  logic [4:0]  r_inc  [4];
  logic [4:0]  r_dep  [4];
  logic [6:0]  r_total;
  logic        r_busy;
  logic        r_done;
  logic        r_conflict;

  logic [15:0] w_lfsr_next [4];
  logic [4:0]  w_raw       [4];
  logic [4:0]  w_dep       [4];
  logic [4:0]  w_room      [4];
  logic [4:0]  w_inc       [4];
  logic [4:0]  w_q_next    [4];
  logic        w_elig      [4];
  logic        w_gate_ns;
  logic        w_gate_ew;
  logic        w_arrive_en;
  logic        w_all_empty;
  logic [6:0]  w_total_next;

  // Per-direction datapath: LFSR step, arrival filter, gated departure, saturation trim
  always_comb begin
    // Both greens high is treated as all-red
    w_gate_ns    = ns_green & ~ew_green;
    w_gate_ew    = ew_green & ~ns_green;
    // enable low stops arrivals on the very edge it is sampled
    w_arrive_en  = (r_state == S_RUN) && enable;
    w_all_empty  = 1'b1;
    w_total_next = '0;
    w_elig[0]    = w_gate_ew;
    w_elig[1]    = w_gate_ew;
    w_elig[2]    = w_gate_ns;
    w_elig[3]    = w_gate_ns;
    for (int i = 0; i < 4; i++) begin
      w_lfsr_next[i] = {r_lfsr[i][14:0],
                        r_lfsr[i][15] ^ r_lfsr[i][13] ^ r_lfsr[i][12] ^ r_lfsr[i][10]};
      w_raw[i] = (w_arrive_en && (r_lfsr[i][2:0] <= LP_MAX)) ? {2'b00, r_lfsr[i][2:0]} : 5'd0;
      // Departures use the pre-arrival queue, so new cars never leave in the same cycle
      if (w_elig[i]) begin
        w_dep[i] = (r_q[i] < LP_DEP) ? r_q[i] : LP_DEP;
      end else begin
        w_dep[i] = 5'd0;
      end
      // dep <= q, so the free space never exceeds 31 and cannot wrap
      w_room[i]    = LP_CAP - r_q[i] + w_dep[i];
      w_inc[i]     = (w_raw[i] > w_room[i]) ? w_room[i] : w_raw[i];
      w_q_next[i]  = r_q[i] + w_inc[i] - w_dep[i];
      w_total_next = w_total_next + {2'b00, w_q_next[i]};
      if (r_q[i] != 5'd0) begin
        w_all_empty = 1'b0;
      end
    end
  end

  // Sequencer FSM with registered counts, queue state and status flags
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr[0]  <= SEED_W;
      r_lfsr[1]  <= SEED_E;
      r_lfsr[2]  <= SEED_N;
      r_lfsr[3]  <= SEED_S;
      for (int i = 0; i < 4; i++) begin
        r_q[i]   <= '0;
        r_inc[i] <= '0;
        r_dep[i] <= '0;
      end
      r_total    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= r_conflict | (ns_green & ew_green);
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < 4; i++) begin
            r_inc[i] <= '0;
            r_dep[i] <= '0;
          end
          if (enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          for (int i = 0; i < 4; i++) begin
            r_lfsr[i] <= w_lfsr_next[i];
            r_q[i]    <= w_q_next[i];
            r_inc[i]  <= w_inc[i];
            r_dep[i]  <= w_dep[i];
          end
          r_total <= w_total_next;
          if (enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else if ((r_state == S_DRAIN) && w_all_empty) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_incomingCars = r_inc[0];
  assign e_incomingCars = r_inc[1];
  assign n_incomingCars = r_inc[2];
  assign s_incomingCars = r_inc[3];
  assign w_leavingCars  = r_dep[0];
  assign e_leavingCars  = r_dep[1];
  assign n_leavingCars  = r_dep[2];
  assign s_leavingCars  = r_dep[3];
  assign total_queued   = r_total;
  assign busy           = r_busy;
  assign done           = r_done;
  assign conflict       = r_conflict;

endmodule

// File: tb/tb_car_flow_generator.sv
// Scoreboard bench for car_flow_generator: two instances (MAX_ARRIVE 3 and 7)
// share the stimulus; a reference model queues expected outputs per edge and
// a monitor compares them, with hand-computed directed checks on top.
module tb_car_flow_generator;

  typedef struct packed {
    logic [3:0][4:0] inc;
    logic [3:0][4:0] lev;
    logic [6:0]      tot;
    logic            busy;
    logic            done;
    logic            conflict;
  } exp_t;

  logic CLK      = 1'b0;
  logic rst      = 1'b1;
  logic enable   = 1'b1;
  logic ns_green = 1'b1;
  logic ew_green = 1'b0;

  wire [1:0][3:0][4:0] inc;
  wire [1:0][3:0][4:0] lev;
  wire [1:0][6:0]      tot;
  wire [1:0]           busy;
  wire [1:0]           done;
  wire [1:0]           conf;

  int n_pass  = 0;
  int n_total = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [15:0] m_lfsr  [2][4];
  int          m_q     [2][4];
  int          m_state [2];
  bit          m_conf  [2];

  always #5 CLK = ~CLK;

  car_flow_generator u_a (
    .CLK(CLK), .rst(rst), .enable(enable), .ns_green(ns_green), .ew_green(ew_green),
    .w_incomingCars(inc[0][0]), .e_incomingCars(inc[0][1]),
    .n_incomingCars(inc[0][2]), .s_incomingCars(inc[0][3]),
    .w_leavingCars(lev[0][0]), .e_leavingCars(lev[0][1]),
    .n_leavingCars(lev[0][2]), .s_leavingCars(lev[0][3]),
    .total_queued(tot[0]), .busy(busy[0]), .done(done[0]), .conflict(conf[0])
  );

  car_flow_generator #(.MAX_ARRIVE(7)) u_b (
    .CLK(CLK), .rst(rst), .enable(enable), .ns_green(ns_green), .ew_green(ew_green),
    .w_incomingCars(inc[1][0]), .e_incomingCars(inc[1][1]),
    .n_incomingCars(inc[1][2]), .s_incomingCars(inc[1][3]),
    .w_leavingCars(lev[1][0]), .e_leavingCars(lev[1][1]),
    .n_leavingCars(lev[1][2]), .s_leavingCars(lev[1][3]),
    .total_queued(tot[1]), .busy(busy[1]), .done(done[1]), .conflict(conf[1])
  );

  function automatic string dname(input int d);
    case (d)
      0:       return "w";
      1:       return "e";
      2:       return "n";
      default: return "s";
    endcase
  endfunction

  function automatic logic [15:0] seed(input int d);
    case (d)
      0:       return 16'hACE1;
      1:       return 16'h1D2B;
      2:       return 16'h7F03;
      default: return 16'h3C55;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: one clock edge of instance k (MAX_ARRIVE 3 or 7, DEPART_RATE 2)
  task automatic model_step(input int k, input bit r, input bit en, input bit ns,
                            input bit ew, output exp_t e);
    int  mx, a, dep, nxt, sum;
    bit  elig, empty;
    e = '0;
    if (r) begin
      for (int d = 0; d < 4; d++) begin
        m_lfsr[k][d] = seed(d);
        m_q[k][d]    = 0;
      end
      m_state[k] = 0;
      m_conf[k]  = 1'b0;
      return;
    end
    m_conf[k]  = m_conf[k] | (ns & ew);
    e.conflict = m_conf[k];
    mx = (k == 0) ? 3 : 7;
    if (m_state[k] == 0) begin
      nxt = en ? 1 : 0;
    end else begin
      empty = 1'b1;
      for (int d = 0; d < 4; d++) if (m_q[k][d] != 0) empty = 1'b0;
      for (int d = 0; d < 4; d++) begin
        a = 0;
        if (m_state[k] == 1 && en && int'(m_lfsr[k][d][2:0]) <= mx) a = int'(m_lfsr[k][d][2:0]);
        elig = (d < 2) ? (ew && !ns) : (ns && !ew);
        dep  = elig ? ((m_q[k][d] < 2) ? m_q[k][d] : 2) : 0;
        if (m_q[k][d] + a - dep > 31) a = 31 - m_q[k][d] + dep;
        m_q[k][d] = m_q[k][d] + a - dep;
        e.inc[d]  = 5'(a);
        e.lev[d]  = 5'(dep);
        m_lfsr[k][d] = {m_lfsr[k][d][14:0],
                        m_lfsr[k][d][15] ^ m_lfsr[k][d][13] ^ m_lfsr[k][d][12] ^ m_lfsr[k][d][10]};
      end
      if (en) nxt = 1;
      else if (m_state[k] == 2 && empty) begin
        nxt    = 0;
        e.done = 1'b1;
      end else nxt = 2;
    end
    sum = 0;
    for (int d = 0; d < 4; d++) sum += m_q[k][d];
    e.tot      = 7'(sum);
    e.busy     = (nxt != 0);
    m_state[k] = nxt;
  endtask

  task automatic cmp(input int k, input exp_t e);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dut%0d %s_incomingCars", k, dname(d)), int'(inc[k][d]), int'(e.inc[d]));
      chk($sformatf("dut%0d %s_leavingCars", k, dname(d)), int'(lev[k][d]), int'(e.lev[d]));
    end
    chk($sformatf("dut%0d total_queued", k), int'(tot[k]), int'(e.tot));
    chk($sformatf("dut%0d busy", k), int'(busy[k]), int'(e.busy));
    chk($sformatf("dut%0d done", k), int'(done[k]), int'(e.done));
    chk($sformatf("dut%0d conflict", k), int'(conf[k]), int'(e.conflict));
  endtask

  // Monitor: after every edge, pop the expected response and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb0.size() > 0) begin e = sb0.pop_front(); cmp(0, e); end
      if (sb1.size() > 0) begin e = sb1.pop_front(); cmp(1, e); end
    end
  end

  // Apply inputs for the next edge and queue the model's expected response
  task automatic drive(input bit r, input bit en, input bit ns, input bit ew);
    exp_t e;
    @(negedge CLK);
    rst = r; enable = en; ns_green = ns; ew_green = ew;
    model_step(0, r, en, ns, ew, e); sb0.push_back(e);
    model_step(1, r, en, ns, ew, e); sb1.push_back(e);
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_first_arrivals(input string tag);
    chk({tag, " dut0 w_in"}, int'(inc[0][0]), 1);
    chk({tag, " dut0 e_in"}, int'(inc[0][1]), 3);
    chk({tag, " dut0 n_in"}, int'(inc[0][2]), 3);
    chk({tag, " dut0 s_in"}, int'(inc[0][3]), 0);
    chk({tag, " dut1 w_in"}, int'(inc[1][0]), 1);
    chk({tag, " dut1 e_in"}, int'(inc[1][1]), 3);
    chk({tag, " dut1 n_in"}, int'(inc[1][2]), 3);
    chk({tag, " dut1 s_in"}, int'(inc[1][3]), 5);
  endtask

  initial begin
    int done_cnt;
    // Reset held with enable and ns_green high
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("idle->run dut1 busy", int'(busy[1]), 1);
    chk("idle->run dut1 n_in", int'(inc[1][2]), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk_first_arrivals("post-reset");

    // Red hold: queues fill and saturate
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("red hold dut1 total_queued", int'(tot[1]), 124);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("red hold dut1 %s_in", dname(d)), int'(inc[1][d]), 0);
      chk($sformatf("red hold dut1 %s_lev", dname(d)), int'(lev[1][d]), 0);
    end

    // Gated drain on the north/south axis
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      chk($sformatf("ns drain %0d dut1 n_lev", i), int'(lev[1][2]), (i < 15) ? 2 : 1);
      chk($sformatf("ns drain %0d dut1 s_lev", i), int'(lev[1][3]), (i < 15) ? 2 : 1);
      chk($sformatf("ns drain %0d dut1 w_lev", i), int'(lev[1][0]), 0);
    end
    chk("ns drain dut1 total_queued", int'(tot[1]), 62);

    // East/west drain, then completion
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      chk($sformatf("ew drain %0d dut1 e_lev", i), int'(lev[1][1]), (i < 15) ? 2 : 1);
      chk($sformatf("ew drain %0d dut1 n_lev", i), int'(lev[1][2]), 0);
      chk($sformatf("ew drain %0d dut1 e_in", i), int'(inc[1][1]), 0);
    end
    chk("ew drain dut1 busy", int'(busy[1]), 1);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      if (i == 0) chk("drain end dut1 done", int'(done[1]), 1);
      done_cnt += int'(done[1]);
    end
    chk("drain end dut1 done pulses", done_cnt, 1);
    chk("drain end dut1 busy", int'(busy[1]), 0);
    chk("drain end dut0 busy", int'(busy[0]), 0);

    // Conflict: both greens high for one cycle
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 4; d++)
        chk($sformatf("conflict dut%0d %s_lev", k, dname(d)), int'(lev[k][d]), 0);
      chk($sformatf("conflict dut%0d flag", k), int'(conf[k]), 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      chk($sformatf("conflict sticky %0d dut0", i), int'(conf[0]), 1);
      chk($sformatf("conflict sticky %0d dut1", i), int'(conf[1]), 1);
    end

    // Asynchronous reset mid-RUN with queues nonzero
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("pre-reset dut1 queued nonzero", int'(tot[1] != 7'd0), 1);
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("async rst dut%0d %s_in", k, dname(d)), int'(inc[k][d]), 0);
        chk($sformatf("async rst dut%0d %s_lev", k, dname(d)), int'(lev[k][d]), 0);
      end
      chk($sformatf("async rst dut%0d total_queued", k), int'(tot[k]), 0);
      chk($sformatf("async rst dut%0d busy", k), int'(busy[k]), 0);
      chk($sformatf("async rst dut%0d conflict", k), int'(conf[k]), 0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk_first_arrivals("re-reset");
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("scoreboard0 empty", sb0.size(), 0);
    chk("scoreboard1 empty", sb1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
